// File: rtl/fprint_mem_copy_master.sv
// fprint_mem_copy_master
// Avalon-MM master that copies a block of words from one region of a
// single-port on-chip memory into another region of the same memory.
// Each word takes three cycles: read, read-latency wait, write.
// Pointers wrap at MEM_DEPTH so a region may straddle the top of memory.

module fprint_mem_copy_master #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 153600
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_WIDTH-1:0]   src_addr,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    input  logic [ADDR_WIDTH-1:0]   num_words,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [ADDR_WIDTH-1:0]   words_done,
    output logic [ADDR_WIDTH-1:0]   m_address,
    output logic [DATA_WIDTH/8-1:0] m_byteenable,
    output logic                    m_chipselect,
    output logic                    m_write,
    output logic [DATA_WIDTH-1:0]   m_writedata,
    input  logic [DATA_WIDTH-1:0]   m_readdata,
    output logic                    m_clken,
    output logic                    m_reset_req
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LAT,
        WR,
        FIN
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   src_ptr;
    logic [ADDR_WIDTH-1:0]   dst_ptr;
    logic [ADDR_WIDTH-1:0]   remaining;
    logic                    abort_flag;

    // Word pointer increment that wraps from the last memory word back to 0.
    function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    // The memory is never clock-gated and never asked to reset.
    assign m_clken     = 1'b1;
    assign m_reset_req = 1'b0;

    // Copy sequencer; bus strobes are registered together with the state so
    // that each state's access is presented during that state's cycle.
    // m_writedata doubles as the holding register for the word just read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            src_ptr      <= '0;
            dst_ptr      <= '0;
            remaining    <= '0;
            abort_flag   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            words_done   <= '0;
            m_address    <= '0;
            m_byteenable <= '0;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            m_writedata  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr    <= src_addr;
                        dst_ptr    <= dst_addr;
                        remaining  <= num_words;
                        words_done <= '0;
                        aborted    <= 1'b0;
                        abort_flag <= 1'b0;
                        busy       <= 1'b1;
                        if (num_words != '0) begin
                            state        <= RD;
                            m_chipselect <= 1'b1;
                            m_write      <= 1'b0;
                            m_byteenable <= '1;
                            m_address    <= src_addr;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                RD: begin
                    m_chipselect <= 1'b0;
                    m_byteenable <= '0;
                    if (abort) begin
                        abort_flag <= 1'b1;
                        state      <= FIN;
                    end else begin
                        state <= LAT;
                    end
                end
                LAT: begin
                    if (abort) begin
                        abort_flag <= 1'b1;
                        state      <= FIN;
                    end else begin
                        m_writedata  <= m_readdata;
                        m_chipselect <= 1'b1;
                        m_write      <= 1'b1;
                        m_byteenable <= '1;
                        m_address    <= dst_ptr;
                        state        <= WR;
                    end
                end
                WR: begin
                    words_done <= words_done + 1'b1;
                    src_ptr    <= wrap_inc(src_ptr);
                    dst_ptr    <= wrap_inc(dst_ptr);
                    remaining  <= remaining - 1'b1;
                    m_write    <= 1'b0;
                    if (abort) begin
                        abort_flag <= 1'b1;
                    end
                    if ((remaining > 1) && !abort) begin
                        state        <= RD;
                        m_chipselect <= 1'b1;
                        m_byteenable <= '1;
                        m_address    <= wrap_inc(src_ptr);
                    end else begin
                        state        <= FIN;
                        m_chipselect <= 1'b0;
                        m_byteenable <= '0;
                    end
                end
                FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    aborted <= abort_flag;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fprint_mem_copy_master.sv
// tb_fprint_mem_copy_master
// Directed bench: a behavioural single-port memory with read latency 1 sits on
// the master's bus and logs every access; the initial block runs the copies.

module tb_fprint_mem_copy_master;

    localparam int AW    = 18;
    localparam int DW    = 32;
    localparam int DEPTH = 153600;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW-1:0] num_words = '0;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW-1:0] words_done;
    logic [AW-1:0] m_address;
    logic [DW/8-1:0] m_byteenable;
    logic          m_chipselect;
    logic          m_write;
    logic [DW-1:0] m_writedata;
    logic [DW-1:0] m_readdata = '0;
    logic          m_clken;
    logic          m_reset_req;

    logic [DW-1:0] mem [int];
    int            cs_count = 0;
    int            be_err = 0;
    int            rd_log[$];
    int            wr_log[$];
    int            checks = 0;
    int            failures = 0;

    fprint_mem_copy_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .abort(abort),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .num_words(num_words),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .words_done(words_done),
        .m_address(m_address),
        .m_byteenable(m_byteenable),
        .m_chipselect(m_chipselect),
        .m_write(m_write),
        .m_writedata(m_writedata),
        .m_readdata(m_readdata),
        .m_clken(m_clken),
        .m_reset_req(m_reset_req)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    function automatic logic [DW-1:0] mem_read(input int a);
        if (mem.exists(a)) return mem[a];
        return init_val(a);
    endfunction

    // Memory model: writes land at the edge, reads return data the next cycle.
    always @(posedge clk) begin
        if (m_chipselect) begin
            cs_count++;
            if (m_write) begin
                mem[int'(m_address)] = m_writedata;
                wr_log.push_back(int'(m_address));
            end else begin
                m_readdata <= mem_read(int'(m_address));
                rd_log.push_back(int'(m_address));
            end
        end
        if (reset_n && (m_byteenable !== (m_chipselect ? 4'hF : 4'h0))) be_err++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int s, input int d, input int n);
        src_addr  = AW'(s);
        dst_addr  = AW'(d);
        num_words = AW'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic waitDone(input string tag, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $error("[TB] FAIL %s_timeout observed=no_done expected=done", tag);
        end
    endtask

    initial begin
        int n;
        int snap;
        int rb;
        int wb;
        int exp_rd[4];

        // reset state
        #2 reset_n = 1'b0;
        tick();
        tick();
        checkOutput("reset_flags", {busy, done, aborted, m_chipselect, m_write}, 0);
        checkOutput("reset_words_done", words_done, 0);
        checkOutput("reset_address", m_address, 0);
        checkOutput("reset_writedata", m_writedata, 0);
        checkOutput("reset_byteenable", m_byteenable, 0);
        checkOutput("clken", m_clken, 1);
        checkOutput("reset_req", m_reset_req, 0);
        reset_n = 1'b1;
        tick();

        // basic copy of 4 words
        $display("[TB] copy 100->200 n=4");
        applyStimulus(100, 200, 4);
        checkOutput("basic_busy", busy, 1);
        waitDone("basic", n);
        checkOutput("basic_latency", 1 + n, 14);
        checkOutput("basic_busy_at_done", busy, 0);
        checkOutput("basic_words_done", words_done, 4);
        checkOutput("basic_aborted", aborted, 0);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("basic_mem%0d", 200 + i), mem_read(200 + i), init_val(100 + i));
        tick();
        checkOutput("basic_done_width", done, 0);
        checkOutput("basic_words_hold", words_done, 4);

        // zero-length copy
        $display("[TB] copy n=0");
        snap = cs_count;
        applyStimulus(5, 6, 0);
        waitDone("zero", n);
        checkOutput("zero_latency", 1 + n, 2);
        checkOutput("zero_words_done", words_done, 0);
        checkOutput("zero_no_access", cs_count - snap, 0);
        tick();

        // wrapping source pointer
        $display("[TB] copy 153598->10 n=4");
        rb = rd_log.size();
        wb = wr_log.size();
        exp_rd = '{153598, 153599, 0, 1};
        applyStimulus(153598, 10, 4);
        waitDone("wrap", n);
        checkOutput("wrap_latency", 1 + n, 14);
        checkOutput("wrap_reads", rd_log.size() - rb, 4);
        checkOutput("wrap_writes", wr_log.size() - wb, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("wrap_rd%0d", i), rd_log[rb + i], exp_rd[i]);
            checkOutput($sformatf("wrap_wr%0d", i), wr_log[wb + i], 10 + i);
            checkOutput($sformatf("wrap_mem%0d", 10 + i), mem_read(10 + i), init_val(exp_rd[i]));
        end
        tick();

        // abort in the third word's LAT cycle
        $display("[TB] abort during word 3 latency");
        wb = wr_log.size();
        applyStimulus(300, 400, 8);
        repeat (7) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        waitDone("abort", n);
        checkOutput("abort_latency", 9 + n, 10);
        checkOutput("abort_aborted", aborted, 1);
        checkOutput("abort_words_done", words_done, 2);
        checkOutput("abort_writes", wr_log.size() - wb, 2);
        checkOutput("abort_mem400", mem_read(400), init_val(300));
        checkOutput("abort_mem401", mem_read(401), init_val(301));
        checkOutput("abort_no_mem402", mem.exists(402), 0);
        tick();

        // abort while idle does nothing
        snap = cs_count;
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        tick();
        checkOutput("idle_abort_busy", busy, 0);
        checkOutput("idle_abort_no_access", cs_count - snap, 0);
        checkOutput("idle_abort_aborted_hold", aborted, 1);

        // start+abort together, then a second start while busy
        $display("[TB] start while busy");
        rb = rd_log.size();
        abort = 1'b1;
        applyStimulus(500, 600, 3);
        abort = 1'b0;
        checkOutput("busy_start_busy", busy, 1);
        checkOutput("busy_start_aborted_clr", aborted, 0);
        tick();
        tick();
        src_addr  = AW'(700);
        dst_addr  = AW'(750);
        num_words = AW'(1);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        waitDone("busy", n);
        checkOutput("busy_latency", 4 + n, 11);
        checkOutput("busy_aborted", aborted, 0);
        checkOutput("busy_words_done", words_done, 3);
        checkOutput("busy_reads", rd_log.size() - rb, 3);
        checkOutput("busy_rd_first", rd_log[rb], 500);
        checkOutput("busy_rd_last", rd_log[rb + 2], 502);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("busy_mem%0d", 600 + i), mem_read(600 + i), init_val(500 + i));
        checkOutput("busy_no_mem750", mem.exists(750), 0);
        tick();

        // reset asserted in the middle of a write
        $display("[TB] reset mid-copy");
        applyStimulus(800, 900, 4);
        for (int i = 0; i < 20; i++) begin
            if (m_write === 1'b1) break;
            tick();
        end
        checkOutput("midrst_reached_wr", m_write, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_flags", {busy, done, aborted, m_chipselect, m_write}, 0);
        checkOutput("midrst_words_done", words_done, 0);
        checkOutput("midrst_address", m_address, 0);
        checkOutput("midrst_writedata", m_writedata, 0);
        checkOutput("midrst_byteenable", m_byteenable, 0);
        tick();
        tick();
        reset_n = 1'b1;
        snap = cs_count;
        repeat (20) tick();
        checkOutput("midrst_no_access", cs_count - snap, 0);
        checkOutput("midrst_busy", busy, 0);

        checkOutput("byteenable_track", be_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
